barrel_shifter_pipe: RTL and testbench
======================================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width; legal values are powers of two, minimum 2.
REQ-002 The block SHALL have parameter SH_W, default $clog2(WIDTH), meaning shift-amount width and pipeline depth; it is derived and is not overridden.
REQ-003 The block SHALL have the following ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- in_valid  input  1: input beat present.
- in_ready  output  1: block accepts the beat this cycle.
- in_data  input  WIDTH: operand.
- in_shamt  input  SH_W: shift amount, 0..WIDTH-1.
- in_dir  input  1: 0 = left, 1 = right.
- in_rotate  input  1: rotate mode.
- in_sra  input  1: arithmetic mode; right shifts only.
- in_fill  input  1: vacated-bit value for logical shifts.
- out_valid  output  1: result present.
- out_ready  input  1: downstream accepts the result.
- out_data  output  WIDTH: result.
- busy  output  1: any pipeline stage holds a valid beat.

Function
REQ-004 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; all in_* fields SHALL be captured together.
REQ-005 The pipeline SHALL have exactly SH_W registered stages; stage k (k=0..SH_W-1) SHALL apply a shift of 2^(SH_W-1-k) when shamt bit (SH_W-1-k) is 1, and pass the data unchanged otherwise.
REQ-006 Each stage SHALL carry its data, the remaining shamt bits, dir, rotate, sra, fill and a valid bit.
REQ-007 Mode priority SHALL be rotate > sra > fill:
- rotate=1: bits shifted out re-enter at the opposite end.
- Else sra=1 and dir=1: vacated bits take the operand MSB captured at acceptance.
- Else: vacated bits take in_fill.
REQ-008 sra=1 with dir=0 SHALL behave as a logical left shift using in_fill.
REQ-009 shamt=0 SHALL return in_data unchanged in every mode.
REQ-010 Latency SHALL be SH_W cycles from acceptance to out_valid with out_ready held at 1; throughput SHALL be one beat per cycle.
REQ-011 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage SHALL advance when out_ready=1.
REQ-012 in_ready SHALL equal (stage 0 empty) OR (stage 0 advancing); this is a combinational path from out_ready.
REQ-013 While out_valid=1 and out_ready=0, out_data and all stage contents SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-014 Simultaneous acceptance and output on the same edge SHALL be legal when the pipeline is full with out_ready=1.
REQ-015 out_data SHALL be driven from the last-stage register only, with no combinational path from in_*.
REQ-016 busy SHALL be the OR of all stage valid bits.
REQ-017 in_shamt bits are all significant, so no value is out of range.

Reset
REQ-018 While rst=1, all valid bits, data registers and mode registers SHALL be 0.
REQ-019 While rst=1, out_valid=0, out_data=0 and busy=0 SHALL hold; in_ready SHALL be 1 on the first cycle after rst falls.
REQ-020 Assertion of rst mid-operation SHALL discard all in-flight beats immediately, without waiting for a clock edge.

Verification (WIDTH=8, SH_W=3, out_ready=1 unless stated)
REQ-021 SLL and fill cases:
- in_data=0xB5, shamt=3, dir=0, fill=0 -> out_data=0xA8 exactly 3 cycles after acceptance.
- Same beat with fill=1 -> out_data=0xAF.
REQ-022 SRL/SRA cases:
- 0xB5, shamt=3, dir=1, fill=0 -> 0x16.
- Same beat with sra=1 -> 0xF6.
- 0x75, shamt=7, dir=1, sra=1 -> 0x00.
REQ-023 Rotate cases:
- 0xB5, shamt=3, rotate=1, dir=0 -> 0xAD.
- Same beat with dir=1 -> 0xB6.
- rotate=1, sra=1, dir=1 -> 0xB6, since rotate wins.
REQ-024 Streaming and backpressure:
- Five back-to-back beats, shamt=0..4, SLL of 0x01 -> outputs 0x01, 0x02, 0x04, 0x08, 0x10 in order on consecutive cycles.
- out_ready=0 for 4 cycles mid-stream -> in_ready=0 once all 3 stages are full, out_data stable, order preserved after release.
REQ-025 Reset mid-stream:
- 2 beats in flight, rst asserted asynchronously -> out_valid=0 and busy=0 before the next clock edge.
- After release, neither beat appears and a new beat completes with latency 3.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined barrel shifter, one shift-amount bit per registered stage
module barrel_shifter_pipe #(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic             in_dir,
    input  logic             in_rotate,
    input  logic             in_sra,
    input  logic             in_fill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [SH_W-1:0] valid;
    logic [SH_W-1:0] adv;
    logic [SH_W-1:0] en;

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input int               s,
        input logic             dir,
        input logic             rot,
        input logic             vac
    );
        logic [WIDTH-1:0] r;
        int               idx;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!dir) begin
                idx  = (i - s + WIDTH) % WIDTH;
                r[i] = (i >= s || rot) ? d[idx[SH_W-1:0]] : vac;
            end else begin
                idx  = (i + s) % WIDTH;
                r[i] = (i + s < WIDTH || rot) ? d[idx[SH_W-1:0]] : vac;
            end
        end
        return r;
    endfunction

    // A full run of stages can only move if a bubble exists above it or the sink takes a beat;
    // computing it this way avoids a combinational chain through adv itself.
    always_comb begin
        logic full_above;
        adv = '0;
        for (int k = 0; k < SH_W; k++) begin
            full_above = 1'b1;
            for (int j = k + 1; j < SH_W; j++) begin
                full_above = full_above & valid[j];
            end
            adv[k] = valid[k] & (out_ready | ~full_above);
        end
    end

    assign en       = ~valid | adv;
    assign in_ready = en[0];

    for (genvar k = 0; k < SH_W; k++) begin : g_stage
        localparam int              SHIFT = 1 << (SH_W - 1 - k);
        localparam logic [SH_W-1:0] BIT   = SH_W'(1) << (SH_W - 1 - k);

        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [SH_W-1:0]  src_shamt;
        logic             src_dir;
        logic             src_rot;
        logic             src_sra;
        logic             src_fill;
        logic             src_sign;
        logic             vac;
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        if (k == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_shamt = in_shamt;
            assign src_dir   = in_dir;
            assign src_rot   = in_rotate;
            assign src_sra   = in_sra;
            assign src_fill  = in_fill;
            assign src_sign  = in_data[WIDTH-1];
        end else begin : g_next
            assign src_valid = g_stage[k-1].valid_q;
            assign src_data  = g_stage[k-1].data_q;
            assign src_shamt = g_stage[k-1].g_carry.shamt_q;
            assign src_dir   = g_stage[k-1].g_carry.dir_q;
            assign src_rot   = g_stage[k-1].g_carry.rot_q;
            assign src_sra   = g_stage[k-1].g_carry.sra_q;
            assign src_fill  = g_stage[k-1].g_carry.fill_q;
            assign src_sign  = g_stage[k-1].g_carry.sign_q;
        end

        // Arithmetic fill uses the sign of the original operand, carried alongside the data.
        assign vac = (src_sra && src_dir) ? src_sign : src_fill;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (en[k]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    data_q <= |(src_shamt & BIT) ? shift_by(src_data, SHIFT, src_dir, src_rot, vac)
                                                 : src_data;
                end
            end
        end

        if (k < SH_W - 1) begin : g_carry
            logic [SH_W-1:0] shamt_q;
            logic            dir_q;
            logic            rot_q;
            logic            sra_q;
            logic            fill_q;
            logic            sign_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shamt_q <= '0;
                    dir_q   <= 1'b0;
                    rot_q   <= 1'b0;
                    sra_q   <= 1'b0;
                    fill_q  <= 1'b0;
                    sign_q  <= 1'b0;
                end else if (en[k] && src_valid) begin
                    shamt_q <= src_shamt & ~BIT;
                    dir_q   <= src_dir;
                    rot_q   <= src_rot;
                    sra_q   <= src_sra;
                    fill_q  <= src_fill;
                    sign_q  <= src_sign;
                end
            end
        end

        assign valid[k] = valid_q;
    end

    assign out_valid = valid[SH_W-1];
    assign out_data  = g_stage[SH_W-1].data_q;
    assign busy      = |valid;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - directed self-checking bench for barrel_shifter_pipe
module tb_barrel_shifter_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_shamt = '0;
    logic       in_dir = 1'b0;
    logic       in_rotate = 1'b0;
    logic       in_sra = 1'b0;
    logic       in_fill = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] q_data[$];
    int         q_cyc[$];

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
        .in_dir(in_dir), .in_rotate(in_rotate), .in_sra(in_sra), .in_fill(in_fill),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_beat(input string tag, input logic [7:0] d, input logic [2:0] sh,
                            input logic dir, input logic rot, input logic sra, input logic fill,
                            input logic [7:0] exp);
        int lat;
        @(posedge clk); #1;
        in_data = d; in_shamt = sh; in_dir = dir; in_rotate = rot; in_sra = sra; in_fill = fill;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat <= 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check(tag, out_data, exp);
    endtask

    initial begin
        int i;
        logic acc;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        run_beat("sll",       8'hB5, 3'd3, 0, 0, 0, 0, 8'hA8);
        run_beat("sll_fill",  8'hB5, 3'd3, 0, 0, 0, 1, 8'hAF);
        run_beat("srl",       8'hB5, 3'd3, 1, 0, 0, 0, 8'h16);
        run_beat("sra",       8'hB5, 3'd3, 1, 0, 1, 0, 8'hF6);
        run_beat("sra_pos7",  8'h75, 3'd7, 1, 0, 1, 0, 8'h00);
        run_beat("rol",       8'hB5, 3'd3, 0, 1, 0, 0, 8'hAD);
        run_beat("ror",       8'hB5, 3'd3, 1, 1, 0, 0, 8'hB6);
        run_beat("ror_sra",   8'hB5, 3'd3, 1, 1, 1, 0, 8'hB6);
        run_beat("sra_left",  8'hB5, 3'd3, 0, 0, 1, 1, 8'hAF);
        run_beat("zero_sra",  8'hB5, 3'd0, 1, 0, 1, 1, 8'hB5);
        run_beat("zero_rot",  8'h3C, 3'd0, 0, 1, 0, 1, 8'h3C);

        // five back-to-back beats
        repeat (2) @(posedge clk);
        q_data.delete(); q_cyc.delete();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_data = 8'h01; in_shamt = k[2:0]; in_dir = 0; in_rotate = 0; in_sra = 0; in_fill = 0;
            in_valid = 1'b1;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        check("stream_count", q_data.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stream_data%0d", k), (k < q_data.size()) ? q_data[k] : 8'hxx, 8'h01 << k);
            check($sformatf("stream_cyc%0d", k), (k < q_cyc.size()) ? q_cyc[k] - q_cyc[0] : -1, k);
        end

        // backpressure: sink stalls for four cycles while the source keeps pushing
        q_data.delete(); q_cyc.delete();
        i = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 3 && c < 7);
            in_valid  = (i < 6);
            in_data   = 8'h01;
            in_shamt  = i[2:0];
            @(negedge clk);
            if (c >= 3 && c < 7) begin
                check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
                check($sformatf("bp_hold_c%0d", c), out_data, 8'h01);
                check($sformatf("bp_valid_c%0d", c), out_valid, 1);
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
            #1;
            c++;
            out_ready = !(c >= 3 && c < 7);
            in_valid  = (i < 6);
            in_shamt  = i[2:0];
            @(negedge clk);
            if (c >= 3 && c < 7) begin
                check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
                check($sformatf("bp_hold_c%0d", c), out_data, 8'h01);
            end
            acc = in_valid && in_ready;
            if (acc) i++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        check("bp_accepted", i, 6);
        check("bp_count", q_data.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp_data%0d", k), (k < q_data.size()) ? q_data[k] : 8'hxx, 8'h01 << k);
        end

        // asynchronous reset with two beats in flight
        @(posedge clk); #1;
        in_data = 8'hFF; in_shamt = 3'd1; in_dir = 0; in_rotate = 0; in_sra = 0; in_fill = 0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h0F; in_shamt = 3'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rst_in_ready", in_ready, 1);
        q_data.delete(); q_cyc.delete();
        run_beat("post_rst", 8'h33, 3'd1, 0, 0, 0, 0, 8'h66);
        repeat (6) @(posedge clk);
        check("post_rst_count", q_data.size(), 1);
        check("post_rst_data", (q_data.size() > 0) ? q_data[0] : 8'hxx, 8'h66);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
